alfa_desc: RTL and testbench



---
 rtl/alfa_desc.sv | 79 +++++++
 tb/tb_alfa_desc.sv | 128 ++++++++++++
 2 files changed

// File: rtl/alfa_desc.sv
// ----------------------------------------------------------------------------
// alfa_desc: registered 7-segment decoder that shows the letter name of a
// musical note. It sits beside the note-recognition FSM and shows the note
// currently being entered.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset; blanks the display
//   tom              octave flag (0 = low, 1 = high); only changes the glyph
//                    for the no-note code (blank vs dash)
//   notas1..notas3   3-bit note code, notas1 = MSB
//                    (000 none, 001 C, 010 d, 011 E, 100 F, 101 G, 110 A, 111 b)
//   saida1..saida7   segments a..g, active-high, registered (1 cycle latency)
// ----------------------------------------------------------------------------
module alfa_desc (
    input  logic clk,
    input  logic reset,
    input  logic tom,
    input  logic notas1,
    input  logic notas2,
    input  logic notas3,
    output logic saida1,
    output logic saida2,
    output logic saida3,
    output logic saida4,
    output logic saida5,
    output logic saida6,
    output logic saida7
);

    // Segment vectors are packed {a,b,c,d,e,f,g}.
    localparam logic [6:0] SegBlank = 7'b000_0000;
    localparam logic [6:0] SegDash  = 7'b000_0001;
    localparam logic [6:0] SegC     = 7'b100_1110;
    localparam logic [6:0] SegD     = 7'b011_1101;
    localparam logic [6:0] SegE     = 7'b100_1111;
    localparam logic [6:0] SegF     = 7'b100_0111;
    localparam logic [6:0] SegG     = 7'b101_1110;
    localparam logic [6:0] SegA     = 7'b111_0111;
    localparam logic [6:0] SegB     = 7'b001_1111;

    logic [2:0] w_code;
    logic [6:0] w_seg;
    logic [6:0] r_seg;

    assign w_code = {notas1, notas2, notas3};

    always_comb begin
        w_seg = SegBlank;
        unique case (w_code)
            3'b000:  w_seg = tom ? SegDash : SegBlank;
            3'b001:  w_seg = SegC;
            3'b010:  w_seg = SegD;
            3'b011:  w_seg = SegE;
            3'b100:  w_seg = SegF;
            3'b101:  w_seg = SegG;
            3'b110:  w_seg = SegA;
            3'b111:  w_seg = SegB;
            default: w_seg = SegBlank;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= SegBlank;
        end else begin
            r_seg <= w_seg;
        end
    end

    assign saida1 = r_seg[6];
    assign saida2 = r_seg[5];
    assign saida3 = r_seg[4];
    assign saida4 = r_seg[3];
    assign saida5 = r_seg[2];
    assign saida6 = r_seg[1];
    assign saida7 = r_seg[0];

endmodule

// File: tb/tb_alfa_desc.sv
module tb_alfa_desc;

    logic clk;
    logic reset;
    logic tom;
    logic notas1;
    logic notas2;
    logic notas3;
    logic saida1, saida2, saida3, saida4, saida5, saida6, saida7;
    logic [6:0] seg;

    int total;
    int bad;

    alfa_desc dut (
        .clk    (clk),
        .reset  (reset),
        .tom    (tom),
        .notas1 (notas1),
        .notas2 (notas2),
        .notas3 (notas3),
        .saida1 (saida1),
        .saida2 (saida2),
        .saida3 (saida3),
        .saida4 (saida4),
        .saida5 (saida5),
        .saida6 (saida6),
        .saida7 (saida7)
    );

    assign seg = {saida1, saida2, saida3, saida4, saida5, saida6, saida7};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] exp);
        total++;
        assert (seg === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, seg, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic t, input logic [2:0] code);
        reset  = r;
        tom    = t;
        notas1 = code[2];
        notas2 = code[1];
        notas3 = code[0];
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic t, input logic [2:0] code,
                        input logic [6:0] exp, input string tag);
        set_in(r, t, code);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    logic [6:0] glyph [8];

    initial begin
        total = 0;
        bad   = 0;
        glyph[0] = 7'b0000000;
        glyph[1] = 7'b1001110;
        glyph[2] = 7'b0111101;
        glyph[3] = 7'b1001111;
        glyph[4] = 7'b1000111;
        glyph[5] = 7'b1011110;
        glyph[6] = 7'b1110111;
        glyph[7] = 7'b0011111;

        set_in(1'b1, 1'b0, 3'b110);
        @(negedge clk);

        // Reset held with la on the inputs.
        step(1'b1, 1'b0, 3'b110, 7'b0000000, "reset_edge1");
        step(1'b1, 1'b0, 3'b110, 7'b0000000, "reset_edge2");
        step(1'b0, 1'b0, 3'b110, 7'b1110111, "release_A");

        // Sweep, low octave.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 3'(i), glyph[i], $sformatf("sweep_t0_%0d", i));
        end

        // Sweep, high octave: only code 000 differs.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'(i), (i == 0) ? 7'b0000001 : glyph[i],
                 $sformatf("sweep_t1_%0d", i));
        end

        // Latency: input change between edges must not show until the next edge.
        step(1'b0, 1'b0, 3'b001, 7'b1001110, "lat_C");
        set_in(1'b0, 1'b0, 3'b100);
        #3;
        check("lat_hold_C", 7'b1001110);
        @(negedge clk);
        check("lat_hold_C_neg", 7'b1001110);
        @(posedge clk);
        #1;
        check("lat_F", 7'b1000111);

        // Reset mid-run.
        step(1'b0, 1'b0, 3'b101, 7'b1011110, "mid_G");
        step(1'b1, 1'b0, 3'b101, 7'b0000000, "mid_reset");
        step(1'b0, 1'b0, 3'b111, 7'b0011111, "mid_release_b");

        // Reset wins even with a dash-producing input.
        step(1'b1, 1'b1, 3'b000, 7'b0000000, "reset_prio_dash");

        // Toggle tom only on code 000.
        step(1'b0, 1'b1, 3'b000, 7'b0000001, "tog_dash1");
        step(1'b0, 1'b0, 3'b000, 7'b0000000, "tog_blank1");
        step(1'b0, 1'b1, 3'b000, 7'b0000001, "tog_dash2");
        step(1'b0, 1'b0, 3'b000, 7'b0000000, "tog_blank2");

        // tom must not alter a real note glyph.
        step(1'b0, 1'b1, 3'b010, 7'b0111101, "tom_d");
        step(1'b0, 1'b0, 3'b010, 7'b0111101, "notom_d");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
